// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter with change detection, overflow
// saturation and a leading-zero blanking mask for the seven-segment driver.
module bin2bcd_seq #(
    parameter int BIN_W    = 20,
    parameter int DIGITS   = 6,
    parameter int MAX_VAL  = 999999,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rstn_signal,
    input  logic [BIN_W-1:0]      bin_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [DIGITS-1:0]     digit_en_o,
    output logic                  ovf_o,
    output logic                  busy_o,
    output logic                  update_o
);

    localparam int                  CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0]    MAX_BIN  = BIN_W'(MAX_VAL);
    localparam logic [4*DIGITS-1:0] ALL_NINE = {DIGITS{4'h9}};
    localparam logic [DIGITS-1:0]   EN_RST   = (BLANK_LZ == 0) ? {DIGITS{1'b1}} : DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [BIN_W-1:0]    ref_q, ref_d;
    logic [BIN_W-1:0]    shift_q, shift_d;
    logic [4*DIGITS-1:0] scratch_q, scratch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovfNext_q, ovfNext_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   digitEn_q, digitEn_d;
    logic                ovf_q, ovf_d;
    logic                update_q, update_d;

    logic [4*DIGITS-1:0] adjusted;
    logic [DIGITS-1:0]   mask;
    logic                seen;
    logic                changed;
    logic                tooBig;

    assign changed = (bin_i != ref_q);
    assign tooBig  = (bin_i > MAX_BIN);

    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (changed) begin
                    state_d = tooBig ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != IDLE);
        update_o   = update_q;
        bcd_o      = bcd_q;
        digit_en_o = digitEn_q;
        ovf_o      = ovf_q;
    end

    // Digits are corrected independently; a digit >= 5 never carries into the next.
    always_comb begin
        adjusted = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adjusted[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        mask = '0;
        seen = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen    = seen | (|scratch_q[4*k +: 4]);
            mask[k] = seen;
        end
        mask[0] = 1'b1;
        if ((BLANK_LZ == 0) || ovfNext_q) begin
            mask = {DIGITS{1'b1}};
        end
    end

    always_comb begin
        ref_d     = ref_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        ovfNext_d = ovfNext_q;
        bcd_d     = bcd_q;
        digitEn_d = digitEn_q;
        ovf_d     = ovf_q;
        update_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (changed) begin
                    ref_d = bin_i;
                    if (tooBig) begin
                        scratch_d = ALL_NINE;
                        ovfNext_d = 1'b1;
                    end else begin
                        shift_d   = bin_i;
                        scratch_d = '0;
                        cnt_d     = '0;
                        ovfNext_d = 1'b0;
                    end
                end
            end
            SHIFT: begin
                scratch_d = {adjusted[4*DIGITS-2:0], shift_q[BIN_W-1]};
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q + 1'b1;
            end
            DONE: begin
                bcd_d     = scratch_q;
                ovf_d     = ovfNext_q;
                digitEn_d = mask;
                update_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) begin
            ref_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovfNext_q <= 1'b0;
            bcd_q     <= '0;
            digitEn_q <= EN_RST;
            ovf_q     <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            ref_q     <= ref_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ovfNext_q <= ovfNext_d;
            bcd_q     <= bcd_d;
            digitEn_q <= digitEn_d;
            ovf_q     <= ovf_d;
            update_q  <= update_d;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, saturation, blanking, retrigger and reset.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rstn_signal;
    logic [19:0] binA;
    logic [23:0] bcdA;
    logic [5:0]  enA;
    logic        ovfA, busyA, updA;
    logic [19:0] binB;
    logic [23:0] bcdB;
    logic [5:0]  enB;
    logic        ovfB, busyB, updB;

    int vectors  = 0;
    int failures = 0;

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6), .MAX_VAL(999999), .BLANK_LZ(1)) dut (
        .clk(clk), .rstn_signal(rstn_signal), .bin_i(binA), .bcd_o(bcdA),
        .digit_en_o(enA), .ovf_o(ovfA), .busy_o(busyA), .update_o(updA)
    );

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6), .MAX_VAL(999999), .BLANK_LZ(0)) dutB (
        .clk(clk), .rstn_signal(rstn_signal), .bin_i(binB), .bcd_o(bcdB),
        .digit_en_o(enB), .ovf_o(ovfB), .busy_o(busyB), .update_o(updB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive a new value at a falling edge, then watch until the update pulse appears.
    task automatic applyStimulus(input string tag, input logic [19:0] value, input logic [23:0] expBcd,
                                 input logic [5:0] expEn, input logic expOvf, input int expLat);
        int cycles;
        int busyCnt;
        int glitches;
        logic [23:0] heldBcd;
        logic        heldOvf;
        heldBcd  = bcdA;
        heldOvf  = ovfA;
        cycles   = 0;
        busyCnt  = 0;
        glitches = 0;
        @(negedge clk);
        binA = value;
        do begin
            @(negedge clk);
            cycles++;
            if (busyA) busyCnt++;
            if (!updA && (bcdA !== heldBcd || ovfA !== heldOvf)) glitches++;
        end while (!updA && cycles < 100);
        checkOutput({tag, "_latency"}, cycles, expLat);
        checkOutput({tag, "_busy"}, busyCnt, expLat - 1);
        checkOutput({tag, "_hold"}, glitches, 0);
        checkOutput({tag, "_bcd"}, bcdA, expBcd);
        checkOutput({tag, "_en"}, enA, expEn);
        checkOutput({tag, "_ovf"}, ovfA, expOvf);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, updA, 0);
    endtask

    initial begin
        int pulses;
        logic [23:0] firstVal;

        rstn_signal = 1'b0;
        binA = '0;
        binB = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_bcd", bcdA, 24'h0);
        checkOutput("rst_en", enA, 6'b000001);
        checkOutput("rst_enB", enB, 6'b111111);
        rstn_signal = 1'b1;

        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (updA) pulses++;
            if (busyA) pulses++;
        end
        checkOutput("idle_activity", pulses, 0);
        checkOutput("idle_bcd", bcdA, 24'h0);
        checkOutput("idle_en", enA, 6'b000001);
        checkOutput("idle_ovf", ovfA, 0);

        applyStimulus("v123", 20'd123, 24'h000123, 6'b000111, 1'b0, 22);
        applyStimulus("v999983", 20'd999983, 24'h999983, 6'b111111, 1'b0, 22);
        applyStimulus("v2", 20'd2, 24'h000002, 6'b000001, 1'b0, 22);
        applyStimulus("vmax", 20'd1048575, 24'h999999, 6'b111111, 1'b1, 2);
        applyStimulus("v10", 20'd10, 24'h000010, 6'b000011, 1'b0, 22);
        applyStimulus("v1000000", 20'd1000000, 24'h999999, 6'b111111, 1'b1, 2);
        applyStimulus("v999999", 20'd999999, 24'h999999, 6'b111111, 1'b0, 22);

        // Retrigger: value changes mid-conversion.
        @(negedge clk);
        binA = 20'd7;
        repeat (5) @(negedge clk);
        binA = 20'd11;
        pulses   = 0;
        firstVal = '1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (updA) begin
                if (pulses == 0) firstVal = bcdA;
                pulses++;
            end
        end
        checkOutput("retrig_pulses", pulses, 2);
        checkOutput("retrig_first", firstVal, 24'h000007);
        checkOutput("retrig_final", bcdA, 24'h000011);
        checkOutput("retrig_en", enA, 6'b000011);

        // Reset in the middle of a conversion.
        @(negedge clk);
        binA = 20'd500000;
        repeat (11) @(negedge clk);
        rstn_signal = 1'b0;
        #1;
        checkOutput("midrst_bcd", bcdA, 24'h0);
        checkOutput("midrst_en", enA, 6'b000001);
        checkOutput("midrst_busy", busyA, 0);
        repeat (3) @(negedge clk);
        checkOutput("midrst_upd", updA, 0);
        rstn_signal = 1'b1;
        pulses = 0;
        begin
            int cycles;
            cycles = 0;
            do begin
                @(negedge clk);
                cycles++;
            end while (!updA && cycles < 100);
            checkOutput("postrst_latency", cycles, 22);
        end
        checkOutput("postrst_bcd", bcdA, 24'h500000);
        checkOutput("postrst_en", enA, 6'b111111);

        // Instance without leading-zero blanking.
        @(negedge clk);
        binB = 20'd42;
        repeat (30) @(negedge clk);
        checkOutput("noblank_bcd", bcdB, 24'h000042);
        checkOutput("noblank_en", enB, 6'b111111);
        checkOutput("noblank_ovf", ovfB, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule
